// File: rtl/lut_arb_pkg.sv
// Shared types and defaults for the round-robin LUT arbiter.
package lut_arb_pkg;

  localparam int LUT_ADDR_W = 5;
  localparam int LUT_DATA_W = 49;

  typedef enum logic {
    ARB   = 1'b0,
    BURST = 1'b1
  } arb_state_t;

  // Next index modulo n (n is the requester count).
  function automatic int wrap_inc(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/lut_rr_arbiter_rr_pick.sv
// Combinational round-robin picker: first set bit of valid, searching from ptr upward with wrap.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  valid,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  onehot,
  output logic [IW-1:0] idx,
  output logic          any
);

  // Walk offsets from farthest to nearest so the nearest match wins.
  always_comb begin
    onehot = '0;
    idx    = '0;
    any    = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      int i;
      i = (int'(ptr) + k) % N;
      if (valid[i]) begin
        onehot    = '0;
        onehot[i] = 1'b1;
        idx       = IW'(i);
        any       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/lut_rr_arbiter.sv
// Round-robin arbiter sharing one registered LUT among N_REQ requesters, with optional burst lock.
// Define LUT_ARB_OUTREG_EN to add an output register stage (2-cycle response latency).
module lut_rr_arbiter
  import lut_arb_pkg::*;
#(
  parameter int N_REQ     = 4,
  parameter int ADDR_W    = LUT_ADDR_W,
  parameter int DATA_W    = LUT_DATA_W,
  parameter int MAX_BURST = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ-1:0]        req_lock,
  input  logic [N_REQ*ADDR_W-1:0] req_addr,
  output logic [N_REQ-1:0]        req_ready,
  output logic [ADDR_W-1:0]       lut_addr,
  input  logic [DATA_W-1:0]       lut_dout,
  output logic [N_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]       rsp_data,
  output logic                    busy
);

  // Handshake contract: a beat transfers when req_valid[i] & req_ready[i]; req_ready is a
  // combinational one-hot grant, and each transfer yields one rsp_valid strobe with no backpressure.

  localparam int IW    = $clog2(N_REQ);
  localparam int CNT_W = $clog2(MAX_BURST + 1);

  arb_state_t         state, state_n;
  logic [IW-1:0]      ptr, ptr_n, owner, owner_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic [N_REQ-1:0]   tag_q;
  logic [N_REQ-1:0]   pick_oh, grant;
  logic [IW-1:0]      pick_idx;
  logic               pick_any;
  logic [ADDR_W-1:0]  addr_sel;

  rr_pick #(.N(N_REQ), .IW(IW)) u_pick (
    .valid  (req_valid),
    .ptr    (ptr),
    .onehot (pick_oh),
    .idx    (pick_idx),
    .any    (pick_any)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ARB;
      ptr   <= '0;
      owner <= '0;
      cnt   <= '0;
      tag_q <= '0;
    end else begin
      state <= state_n;
      ptr   <= ptr_n;
      owner <= owner_n;
      cnt   <= cnt_n;
      tag_q <= grant;
    end
  end

  always_comb begin
    state_n  = state;
    ptr_n    = ptr;
    owner_n  = owner;
    cnt_n    = cnt;
    grant    = '0;
    addr_sel = '0;
    case (state)
      ARB: begin
        if (pick_any) begin
          grant    = pick_oh;
          addr_sel = req_addr[int'(pick_idx)*ADDR_W +: ADDR_W];
          if (req_lock[pick_idx] && MAX_BURST > 1) begin
            state_n = BURST;
            owner_n = pick_idx;
            cnt_n   = CNT_W'(1);
          end else begin
            ptr_n = IW'(wrap_inc(int'(pick_idx), N_REQ));
          end
        end
      end
      BURST: begin
        // Any exit from BURST hands the pointer past the owner; others wait a cycle.
        state_n = ARB;
        ptr_n   = IW'(wrap_inc(int'(owner), N_REQ));
        cnt_n   = '0;
        if (req_valid[owner]) begin
          grant[owner] = 1'b1;
          addr_sel     = req_addr[int'(owner)*ADDR_W +: ADDR_W];
          if (req_lock[owner] && cnt != CNT_W'(MAX_BURST - 1)) begin
            state_n = BURST;
            ptr_n   = ptr;
            cnt_n   = cnt + CNT_W'(1);
          end
        end
      end
      default: state_n = ARB;
    endcase
  end

  assign req_ready = rst ? '0 : grant;
  assign lut_addr  = rst ? '0 : addr_sel;

`ifdef LUT_ARB_OUTREG_EN
  logic [N_REQ-1:0]  rsp_valid_q;
  logic [DATA_W-1:0] rsp_data_q;

  // Data only loads on a real response so it stays 0 from reset until the first one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
    end else begin
      rsp_valid_q <= tag_q;
      if (|tag_q) rsp_data_q <= lut_dout;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign busy      = (state == BURST) | (|tag_q) | (|rsp_valid_q);
`else
  assign rsp_valid = tag_q;
  assign rsp_data  = lut_dout;
  assign busy      = (state == BURST) | (|tag_q);
`endif

endmodule

// File: tb/tb_lut_rr_arbiter.sv
// Directed bench for lut_rr_arbiter with a registered LUT model and response queue.
module tb_lut_rr_arbiter;

`ifdef LUT_ARB_OUTREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic        clk;
  logic        rst;
  logic [3:0]  req_valid;
  logic [3:0]  req_lock;
  logic [19:0] req_addr;
  logic [3:0]  req_ready;
  logic [4:0]  lut_addr;
  logic [48:0] lut_dout;
  logic [3:0]  rsp_valid;
  logic [48:0] rsp_data;
  logic        busy;

  int checks;
  int failures;
  logic seen_rsp;
  logic [8:0] exp_q[$];

  lut_rr_arbiter #(.N_REQ(4), .ADDR_W(5), .DATA_W(49), .MAX_BURST(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_lock  (req_lock),
    .req_addr  (req_addr),
    .req_ready (req_ready),
    .lut_addr  (lut_addr),
    .lut_dout  (lut_dout),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .busy      (busy)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [48:0] lut_word(input logic [4:0] a);
    return {a, 12'hABC, a, 27'h1234567};
  endfunction

  initial lut_dout = '0;
  always @(posedge clk) lut_dout <= lut_word(lut_addr);

  function automatic logic [19:0] pack(input logic [4:0] a0, a1, a2, a3);
    return {a3, a2, a1, a0};
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic clear_exp();
    exp_q.delete();
    for (int k = 0; k < LAT; k++) exp_q.push_back('0);
    seen_rsp = 1'b0;
  endtask

  // One cycle: drive inputs, check at negedge against hand-given grant and burst flag.
  task automatic step(input logic [3:0] v, input logic [3:0] lk, input logic [19:0] a,
                      input logic [3:0] eg, input logic eb, input string tag);
    logic [8:0] e;
    logic [4:0] ea;
    logic inflight;
    req_valid = v;
    req_lock  = lk;
    req_addr  = a;
    ea = '0;
    for (int i = 0; i < 4; i++) if (eg[i]) ea = a[i*5 +: 5];
    e = exp_q.pop_front();
    inflight = |e[8:5];
    foreach (exp_q[k]) inflight = inflight | (|exp_q[k][8:5]);
    exp_q.push_back({eg, ea});
    @(negedge clk);
    check({tag, "_ready"}, 64'(req_ready), 64'(eg));
    check({tag, "_addr"}, 64'(lut_addr), 64'(ea));
    check({tag, "_rspv"}, 64'(rsp_valid), 64'(e[8:5]));
    check({tag, "_busy"}, 64'(busy), 64'(eb | inflight));
    if (|e[8:5]) begin
      check({tag, "_rspd"}, 64'(rsp_data), 64'(lut_word(e[4:0])));
      seen_rsp = 1'b1;
    end
`ifdef LUT_ARB_OUTREG_EN
    else if (!seen_rsp) check({tag, "_rspd0"}, 64'(rsp_data), 64'd0);
`endif
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input string tag);
    rst       = 1'b1;
    req_valid = 4'b1111;
    req_lock  = 4'b1111;
    req_addr  = pack(5'd1, 5'd2, 5'd3, 5'd4);
    @(negedge clk);
    check({tag, "_rst_ready"}, 64'(req_ready), 64'd0);
    check({tag, "_rst_addr"}, 64'(lut_addr), 64'd0);
    check({tag, "_rst_rspv"}, 64'(rsp_valid), 64'd0);
    check({tag, "_rst_busy"}, 64'(busy), 64'd0);
`ifdef LUT_ARB_OUTREG_EN
    check({tag, "_rst_rspd"}, 64'(rsp_data), 64'd0);
`endif
    @(posedge clk);
    #1;
    rst = 1'b0;
    clear_exp();
  endtask

  initial begin
    logic [19:0] aa;
    checks = 0;
    failures = 0;
    rst = 1'b1;
    req_valid = '0;
    req_lock = '0;
    req_addr = '0;
    clear_exp();
    #1;
    do_reset("init");

    // single requester 2, addr 9
    step(4'b0100, 4'b0000, pack(5'd0, 5'd0, 5'd9, 5'd0), 4'b0100, 1'b0, "single");
    step(4'b0000, 4'b0000, '0, 4'b0000, 1'b0, "single_rsp");
    step(4'b0000, 4'b0000, '0, 4'b0000, 1'b0, "single_idle");

    // all valid from ptr=0: 0,1,2,3,0 with wrap
    do_reset("rr");
    aa = pack(5'd17, 5'd18, 5'd19, 5'd20);
    step(4'b1111, 4'b0000, aa, 4'b0001, 1'b0, "rr0");
    step(4'b1111, 4'b0000, aa, 4'b0010, 1'b0, "rr1");
    step(4'b1111, 4'b0000, aa, 4'b0100, 1'b0, "rr2");
    step(4'b1111, 4'b0000, aa, 4'b1000, 1'b0, "rr3");
    step(4'b1111, 4'b0000, aa, 4'b0001, 1'b0, "rr_wrap");

    // ptr=1: requester 1 locks 6 cycles, requester 3 valid -> 1,1,1,1,3,1
    aa = pack(5'd0, 5'd5, 5'd0, 5'd30);
    step(4'b1010, 4'b0010, aa, 4'b0010, 1'b0, "bst0");
    step(4'b1010, 4'b0010, aa, 4'b0010, 1'b1, "bst1");
    step(4'b1010, 4'b0010, aa, 4'b0010, 1'b1, "bst2");
    step(4'b1010, 4'b0010, aa, 4'b0010, 1'b1, "bst3_sat");
    step(4'b1010, 4'b0010, aa, 4'b1000, 1'b0, "bst4_other");
    step(4'b1010, 4'b0010, aa, 4'b0010, 1'b0, "bst5_relock");
    // owner 1 drops valid in BURST -> no grant, ptr=2
    step(4'b0000, 4'b0000, aa, 4'b0000, 1'b1, "drop1");

    // steer ptr to 0, then owner 0 drops valid -> next grant to 1
    aa = pack(5'd11, 5'd12, 5'd13, 5'd14);
    step(4'b0100, 4'b0000, aa, 4'b0100, 1'b0, "steer2");
    step(4'b1000, 4'b0000, aa, 4'b1000, 1'b0, "steer3");
    step(4'b0001, 4'b0001, aa, 4'b0001, 1'b0, "lock0");
    step(4'b0010, 4'b0000, aa, 4'b0000, 1'b1, "drop0");
    step(4'b0011, 4'b0000, aa, 4'b0010, 1'b0, "after_drop");

    // release by dropping lock while requester 3 waits -> 3 served next cycle
    step(4'b0100, 4'b0100, aa, 4'b0100, 1'b0, "lock2");
    step(4'b1100, 4'b0000, aa, 4'b0100, 1'b1, "release2");
    step(4'b1100, 4'b0000, aa, 4'b1000, 1'b0, "next3");

    // reset the cycle after a handshake: response discarded, restart from 0
    step(4'b0001, 4'b0000, aa, 4'b0001, 1'b0, "pre_rst");
    do_reset("mid");
    step(4'b1100, 4'b0000, aa, 4'b0100, 1'b0, "post_rst");
    step(4'b0000, 4'b0000, aa, 4'b0000, 1'b0, "flush0");
    step(4'b0000, 4'b0000, aa, 4'b0000, 1'b0, "flush1");
    step(4'b0000, 4'b0000, aa, 4'b0000, 1'b0, "flush2");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
